pic8_controller: RTL

Eight-input priority interrupt controller placed between peripheral interrupt sources (button, timer, etc.) and the mammal CPU's `INT`/`intack` pins. It captures interrupt requests, applies a software-writable mask, and raises `INT` for the highest-priority eligible request. On `intack` it supplies that request's vector on `vector` for the top-level data-in multiplexer, and it tracks in-service levels until software issues an end-of-interrupt (EOI) through a memory-mapped register.

---
 rtl/pic8_controller.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pic8_controller.sv
// rtl/pic8_controller.sv - eight-input fully nested priority interrupt controller
// Optional level-triggered capture: define PIC_LEVEL_TRIG_EN.
module pic8_controller #(
  parameter logic [15:0] VEC_BASE = 16'h0000,
  parameter logic [7:0]  IMR_RST  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  irq,
  input  logic        intack,
  output logic        INT,
  output logic [15:0] vector,
  input  logic        cs,
  input  logic        we,
  input  logic        a0,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t      r_state;
  logic [7:0]  r_irr;
  logic [7:0]  r_isr;
  logic [7:0]  r_imr;
  logic [2:0]  r_cur;
  logic        r_int;
  logic [15:0] r_vector;

  logic [7:0]  w_set;
  logic [7:0]  w_allow;
  logic [7:0]  w_elig;
  logic [7:0]  w_isr_low;
  logic [7:0]  w_eoi_clr;
  logic [7:0]  w_ack_clr;
  logic [2:0]  w_win;
  logic        w_any;
  logic        w_wr;
  logic        w_ack;
  logic        w_unused;

`ifdef PIC_LEVEL_TRIG_EN
  assign w_set = irq;
`else
  logic [7:0] r_irq_d;
  assign w_set = irq & ~r_irq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq_d <= 8'h00;
    else        r_irq_d <= irq;
  end
`endif

  // Only levels strictly above the highest-priority in-service level may interrupt.
  always_comb begin
    logic v_blk;
    v_blk   = 1'b0;
    w_allow = 8'h00;
    for (int i = 0; i < 8; i++) begin
      v_blk      = v_blk | r_isr[i];
      w_allow[i] = ~v_blk;
    end
  end

  assign w_elig = r_irr & ~r_imr & w_allow;
  assign w_any  = |w_elig;

  always_comb begin
    w_win = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_elig[i]) w_win = 3'(i);
    end
  end

  assign w_wr      = cs & we;
  assign w_ack     = (r_state == S_REQ) & intack;
  assign w_isr_low = r_isr & (~r_isr + 8'd1);
  assign w_ack_clr = w_ack ? (8'h01 << r_cur) : 8'h00;

  always_comb begin
    w_eoi_clr = 8'h00;
    if (w_wr && a0) begin
      if (wdata[3]) w_eoi_clr = 8'h01 << wdata[2:0];
      else          w_eoi_clr = w_isr_low;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_irr    <= 8'h00;
      r_isr    <= 8'h00;
      r_imr    <= IMR_RST;
      r_cur    <= 3'd0;
      r_int    <= 1'b0;
      r_vector <= VEC_BASE;
    end else begin
      // New captures override an acknowledge clear of the same bit.
      r_irr <= (r_irr & ~w_ack_clr) | w_set;
      r_isr <= (r_isr & ~w_eoi_clr) | w_ack_clr;
      if (w_wr && !a0) r_imr <= wdata[7:0];

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cur    <= w_win;
            r_state  <= S_REQ;
            r_int    <= 1'b1;
            r_vector <= VEC_BASE + {13'd0, w_win};
          end
        end
        S_REQ: begin
          if (intack) begin
            r_state <= S_ACK;
            r_int   <= 1'b0;
          end
        end
        S_ACK: begin
          if (!intack) begin
            r_state  <= S_IDLE;
            r_vector <= VEC_BASE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_int    <= 1'b0;
          r_vector <= VEC_BASE;
        end
      endcase
    end
  end

  assign INT      = r_int;
  assign vector   = r_vector;
  assign rdata    = !cs ? 16'h0000 : (a0 ? {8'h00, r_imr} : {r_isr, r_irr});
  assign w_unused = &{1'b0, wdata[15:8]};

endmodule
